// File: rtl/ws2811_pkg.sv
// rtl/ws2811_pkg.sv - shared types, constants and helpers for the WS2811 pixel path
package ws2811_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    WAIT,
    GAP
  } seq_state_e;

  // One transmitter bit slot is built from 100 ns ticks derived from the system clock.
  localparam int unsigned HZ_PER_100NS = 10_000_000;

  function automatic int unsigned div_100ns(input int unsigned clock_speed);
    return clock_speed / HZ_PER_100NS;
  endfunction

  function automatic int unsigned gap_cycles(input int unsigned clock_speed,
                                             input int unsigned us);
    return (clock_speed / 1_000_000) * us;
  endfunction

  function automatic logic [23:0] grb_reorder(input logic [23:0] rgb);
    return {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

endpackage

// File: rtl/ws2811_frame_sequencer.sv
// rtl/ws2811_frame_sequencer.sv - walks the pixel RAM and feeds each word to the WS2811 transmitter
module ws2811_frame_sequencer
  import ws2811_pkg::*;
#(
  parameter int CLOCK_SPEED  = 50_000_000,
  parameter int NUM_LEDS     = 64,
  parameter int ADDR_WIDTH   = 6,
  parameter int RESET_GAP_US = 60,
  parameter int RGB_TO_GRB   = 1
) (
  input  logic                  clkIN,
  input  logic                  resetIN,
  input  logic                  frameStartIN,
  output logic [ADDR_WIDTH-1:0] pixelAddrOUT,
  input  logic [23:0]           pixelDataIN,
  output logic                  txStartOUT,
  output logic [23:0]           txDataOUT,
  input  logic                  txBusyIN,
  output logic                  frameBusyOUT,
  output logic                  frameDoneOUT
);

  localparam int GAP_CYCLES = int'(gap_cycles(CLOCK_SPEED, RESET_GAP_US));
  localparam int CNT_W      = $clog2(GAP_CYCLES + 1);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_LEDS - 1);
  localparam logic [CNT_W-1:0]      GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  seq_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [23:0]           data_q, data_d;
  logic                  start_q, start_d;
  logic                  fbusy_q, fbusy_d;
  logic                  done_q, done_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  always_ff @(posedge clkIN) begin
    if (resetIN) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      start_q <= 1'b0;
      fbusy_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      start_q <= start_d;
      fbusy_q <= fbusy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    start_d = start_q;
    fbusy_d = fbusy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        // The transmitter has no reset; never start while it may still be shifting a pixel.
        if (frameStartIN && !txBusyIN) begin
          addr_d  = '0;
          fbusy_d = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        data_d  = (RGB_TO_GRB != 0) ? grb_reorder(pixelDataIN) : pixelDataIN;
        start_d = 1'b1;
        state_d = START;
      end
      START: begin
        if (txBusyIN) begin
          start_d = 1'b0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!txBusyIN) begin
          if (addr_q == LAST_ADDR) begin
            cnt_d   = '0;
            state_d = GAP;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == GAP_LAST) begin
          done_d  = 1'b1;
          fbusy_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pixelAddrOUT = addr_q;
  assign txDataOUT    = data_q;
  assign txStartOUT   = start_q;
  assign frameBusyOUT = fbusy_q;
  assign frameDoneOUT = done_q;

endmodule

// File: tb/tb_ws2811_frame_sequencer.sv
// tb/tb_ws2811_frame_sequencer.sv - directed checks of the frame sequencer against a RAM and transmitter model
module tb_ws2811_frame_sequencer;

  localparam int GAP        = 3000;
  localparam int TX_CYCLES  = 20;
  // Done-to-done spacing for one-pixel frames: FETCH, LOAD, the edge that sees busy, the WAIT exit edge, plus busy time.
  localparam int B_PERIOD   = GAP + TX_CYCLES + 4;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_fs, a_start, a_busy, a_fbusy, a_done;
  logic [1:0]  a_addr;
  logic [23:0] a_pdata, a_txdata;
  logic [23:0] a_ram [4];
  int          a_txcnt;

  logic        b_rst, b_fs, b_start, b_busy, b_fbusy, b_done;
  logic [0:0]  b_addr;
  logic [23:0] b_pdata, b_txdata;
  logic [23:0] b_ram [2];
  int          b_txcnt;

  ws2811_frame_sequencer #(
    .CLOCK_SPEED(50_000_000), .NUM_LEDS(3), .ADDR_WIDTH(2), .RESET_GAP_US(60), .RGB_TO_GRB(1)
  ) dut_a (
    .clkIN(clk), .resetIN(a_rst), .frameStartIN(a_fs), .pixelAddrOUT(a_addr),
    .pixelDataIN(a_pdata), .txStartOUT(a_start), .txDataOUT(a_txdata), .txBusyIN(a_busy),
    .frameBusyOUT(a_fbusy), .frameDoneOUT(a_done)
  );

  ws2811_frame_sequencer #(
    .CLOCK_SPEED(50_000_000), .NUM_LEDS(1), .ADDR_WIDTH(1), .RESET_GAP_US(60), .RGB_TO_GRB(0)
  ) dut_b (
    .clkIN(clk), .resetIN(b_rst), .frameStartIN(b_fs), .pixelAddrOUT(b_addr),
    .pixelDataIN(b_pdata), .txStartOUT(b_start), .txDataOUT(b_txdata), .txBusyIN(b_busy),
    .frameBusyOUT(b_fbusy), .frameDoneOUT(b_done)
  );

  always @(posedge clk) a_pdata <= a_ram[a_addr];
  always @(posedge clk) b_pdata <= b_ram[b_addr];

  // Transmitter stand-in: samples start on the falling edge, busy for TX_CYCLES cycles, ignores reset.
  initial begin a_busy = 1'b0; a_txcnt = 0; b_busy = 1'b0; b_txcnt = 0; end
  always @(negedge clk) begin
    if (a_busy) begin
      if (a_txcnt == 1) a_busy <= 1'b0;
      a_txcnt <= a_txcnt - 1;
    end else if (a_start) begin
      a_busy  <= 1'b1;
      a_txcnt <= TX_CYCLES;
    end
  end
  always @(negedge clk) begin
    if (b_busy) begin
      if (b_txcnt == 1) b_busy <= 1'b0;
      b_txcnt <= b_txcnt - 1;
    end else if (b_start) begin
      b_busy  <= 1'b1;
      b_txcnt <= TX_CYCLES;
    end
  end

  typedef struct {
    logic [23:0] ram;
    logic [23:0] exp_tx;
    logic [1:0]  exp_addr;
  } pix_vec_t;
  pix_vec_t vecs [3];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  int          a_rises, a_dones, a_fall_cyc, a_done_cyc;
  logic        a_fb_at_done, a_fb_before_done;
  logic        a_busy_p, a_start_p, a_fbusy_p;
  logic [23:0] a_txlog [$];
  logic [1:0]  a_addrlog [$];

  int          b_dones;
  int          b_done_cycs [$];
  logic        b_start_p;
  logic [23:0] b_txlog [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (a_busy && !a_busy_p) a_rises++;
    if (!a_busy && a_busy_p) a_fall_cyc = cyc;
    if (a_done) begin
      a_dones++;
      a_done_cyc       = cyc;
      a_fb_at_done     = a_fbusy;
      a_fb_before_done = a_fbusy_p;
    end
    if (a_start && !a_start_p) begin
      a_txlog.push_back(a_txdata);
      a_addrlog.push_back(a_addr);
    end
    if (b_done) begin
      b_dones++;
      b_done_cycs.push_back(cyc);
    end
    if (b_start && !b_start_p) b_txlog.push_back(b_txdata);
    a_busy_p  = a_busy;
    a_start_p = a_start;
    a_fbusy_p = a_fbusy;
    b_start_p = b_start;
  endtask

  task automatic clear_a();
    a_rises = 0;
    a_dones = 0;
    a_fall_cyc = 0;
    a_done_cyc = 0;
    a_txlog.delete();
    a_addrlog.delete();
  endtask

  task automatic wait_a_dones(input int target, input int limit, input string name);
    int n;
    n = 0;
    while (a_dones < target && n < limit) begin
      tick();
      n++;
    end
    chk(name, 32'(a_dones >= target), 32'd1);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_txstart"}, 32'(a_start), 32'd0);
    chk({tag, "_txdata"}, 32'(a_txdata), 32'd0);
    chk({tag, "_addr"}, 32'(a_addr), 32'd0);
    chk({tag, "_fbusy"}, 32'(a_fbusy), 32'd0);
    chk({tag, "_done"}, 32'(a_done), 32'd0);
  endtask

  initial begin
    int n;
    logic viol;

    vecs[0] = '{24'hFF0000, 24'h00FF00, 2'd0};
    vecs[1] = '{24'h00FF00, 24'hFF0000, 2'd1};
    vecs[2] = '{24'h0000FF, 24'h0000FF, 2'd2};
    for (int i = 0; i < 3; i++) a_ram[i] = vecs[i].ram;
    a_ram[3] = 24'h0;
    b_ram[0] = 24'h123456;
    b_ram[1] = 24'h0;

    a_busy_p = 1'b0; a_start_p = 1'b0; a_fbusy_p = 1'b0; b_start_p = 1'b0;
    a_fb_at_done = 1'b0; a_fb_before_done = 1'b0;
    b_dones = 0;
    clear_a();

    a_rst = 1'b1; b_rst = 1'b1; a_fs = 1'b0; b_fs = 1'b0;
    repeat (3) tick();
    a_rst = 1'b0;
    tick();
    chk_reset_a("rst");

    // Full three-pixel frame with GRB reordering
    clear_a();
    a_fs = 1'b1;
    tick();
    a_fs = 1'b0;
    chk("t1_accept_fbusy", 32'(a_fbusy), 32'd1);
    chk("t1_accept_addr", 32'(a_addr), 32'd0);
    wait_a_dones(1, 20000, "t1_done_wait");
    for (int i = 0; i < 3; i++) begin
      if (i < a_txlog.size()) begin
        chk($sformatf("t1_txdata%0d", i), 32'(a_txlog[i]), 32'(vecs[i].exp_tx));
        chk($sformatf("t1_addr%0d", i), 32'(a_addrlog[i]), 32'(vecs[i].exp_addr));
      end else begin
        chk($sformatf("t1_pixel%0d_missing", i), 32'd0, 32'd1);
      end
    end
    chk("t1_busy_periods", 32'(a_rises), 32'd3);
    chk("t1_gap_len", 32'(a_done_cyc - a_fall_cyc), 32'(GAP));
    chk("t1_fbusy_at_done", 32'(a_fb_at_done), 32'd0);
    chk("t1_fbusy_before_done", 32'(a_fb_before_done), 32'd1);
    tick();
    chk("t1_done_one_cycle", 32'(a_done), 32'd0);
    chk("t1_txdata_hold", 32'(a_txdata), 32'h0000FF);
    chk("t1_addr_hold", 32'(a_addr), 32'd2);

    // Request during pixel 1 WAIT is ignored
    clear_a();
    a_fs = 1'b1;
    tick();
    a_fs = 1'b0;
    n = 0;
    while (!(a_addr == 2'd1 && a_busy && !a_start) && n < 1000) begin
      tick();
      n++;
    end
    chk("t2_reach_wait1", 32'(n < 1000), 32'd1);
    a_fs = 1'b1;
    tick();
    a_fs = 1'b0;
    wait_a_dones(1, 20000, "t2_done_wait");
    repeat (50) tick();
    chk("t2_busy_periods", 32'(a_rises), 32'd3);
    chk("t2_pixels", 32'(a_txlog.size()), 32'd3);
    chk("t2_done_count", 32'(a_dones), 32'd1);
    chk("t2_idle_after", 32'(a_fbusy), 32'd0);

    // Reset in START while the transmitter is busy; new frame waits for busy to drop
    clear_a();
    a_fs = 1'b1;
    tick();
    a_fs = 1'b0;
    n = 0;
    while (!a_start && n < 100) begin
      tick();
      n++;
    end
    chk("t3_reach_start", 32'(a_start), 32'd1);
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    a_fs  = 1'b1;
    chk("t3_tx_busy_at_reset", 32'(a_busy), 32'd1);
    chk_reset_a("t3_rst");
    n = 0;
    viol = 1'b0;
    while (n < 200) begin
      tick();
      n++;
      if (!a_busy) break;
      if (a_fbusy) viol = 1'b1;
    end
    chk("t3_busy_dropped", 32'(n < 200), 32'd1);
    chk("t3_no_start_while_busy", 32'(viol), 32'd0);
    chk("t3_restart_fbusy", 32'(a_fbusy), 32'd1);
    chk("t3_restart_addr", 32'(a_addr), 32'd0);
    a_fs = 1'b0;
    wait_a_dones(1, 20000, "t3_done_wait");

    // One-LED instance, request held high: back-to-back frames
    b_rst = 1'b0;
    b_fs  = 1'b1;
    n = 0;
    while (b_dones < 3 && n < 12000) begin
      tick();
      n++;
    end
    b_fs = 1'b0;
    chk("t4_three_frames", 32'(b_dones >= 3), 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (i < b_txlog.size()) chk($sformatf("t4_txdata%0d", i), 32'(b_txlog[i]), 32'h123456);
      else chk($sformatf("t4_pixel%0d_missing", i), 32'd0, 32'd1);
    end
    for (int i = 1; i < 3; i++) begin
      if (i < b_done_cycs.size())
        chk($sformatf("t4_spacing%0d", i), 32'(b_done_cycs[i] - b_done_cycs[i-1]), 32'(B_PERIOD));
      else chk($sformatf("t4_spacing%0d_missing", i), 32'd0, 32'd1);
    end
    chk("t4_addr", 32'(b_addr), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
